// File: rtl/master_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : master_tx_pkg
// Description : Shared state encodings and handshake byte width for master_tx.
// Revision    : 1.0 - initial release
// ============================================================================
package master_tx_pkg;

    localparam int c_BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ABORT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/master_fifo.sv
`default_nettype none
// ============================================================================
// Module      : master_fifo
// Description : Synchronous DEPTH x 8 FIFO with show-ahead head and full/empty/count.
// Revision    : 1.0 - initial release
// ============================================================================
module master_fifo
    import master_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [c_BYTE_W-1:0]      i_wdata,
    input  logic                     i_pop,
    output logic [c_BYTE_W-1:0]      o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_BYTE_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]       r_wr_ptr;
    logic [c_AW:0]       r_rd_ptr;
    logic                w_push;
    logic                w_pop;

    // Extra MSB on each pointer distinguishes full from empty when indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[c_AW-1:0]];

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/master_tx.sv
`default_nettype none
// ============================================================================
// Module      : master_tx
// Description : Byte master toward the slave handshake stage: FIFO, request FSM,
//               ready timeout and transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module master_tx
    import master_tx_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_src_valid,
    input  logic [c_BYTE_W-1:0]  i_src_data,
    output logic                 o_src_ready,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic                 o_data_en,
    output logic [c_BYTE_W-1:0]  o_data_in,
    output logic                 o_busy,
    output logic                 o_timeout_err,
    input  logic                 i_err_clr,
    output logic [CNT_W-1:0]     o_tx_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_TW = $clog2(TIMEOUT);

    state_t              r_state;
    logic                r_req;
    logic                r_busy;
    logic                r_err;
    logic [c_TW-1:0]     r_timer;
    logic [CNT_W-1:0]    r_tx_count;

    logic [c_BYTE_W-1:0] w_head;
    logic                w_full;
    logic                w_empty;
    logic [c_AW:0]       w_count;
    logic                w_push;
    logic                w_pop;
    logic                w_last;

    assign w_push = i_src_valid && !w_full;
    assign w_pop  = r_req && i_ready;
    // The pop drains the FIFO only if nothing refills it on the same edge.
    assign w_last = (w_count == (c_AW+1)'(1)) && !w_push;

    master_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (i_src_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_timer    <= '0;
            r_tx_count <= '0;
        end else begin
            if (i_err_clr) begin
                r_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (!w_empty) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (i_ready) begin
                        r_timer    <= '0;
                        r_tx_count <= r_tx_count + CNT_W'(1);
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_timer == c_TW'(TIMEOUT - 1)) begin
                        // Abort keeps the head byte; a later assignment lets the set beat err_clr.
                        r_state <= S_ABORT;
                        r_req   <= 1'b0;
                        r_timer <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                S_ABORT: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign o_src_ready   = !w_full;
    assign o_valid       = r_req;
    assign o_data_en     = r_req;
    assign o_data_in     = r_req ? w_head : '0;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_err;
    assign o_tx_count    = r_tx_count;

endmodule
`default_nettype wire

// File: tb/tb_master_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_master_tx
// Description : Scoreboard bench for master_tx with a registered-ready slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_master_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       src_ready;
    logic       ready_slv = 1'b0;
    logic       valid;
    logic       data_en;
    logic [7:0] data_in;
    logic       busy;
    logic       timeout_err;
    logic       err_clr = 1'b0;
    logic [3:0] tx_count;
    logic       hold = 1'b0;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_acc   = 0;
    bit         last_acc;
    logic [7:0] exp_q[$];
    int         xfer_cyc[$];
    logic [7:0] m_b;

    master_tx #(
        .DEPTH   (4),
        .TIMEOUT (8),
        .CNT_W   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_src_valid   (src_valid),
        .i_src_data    (src_data),
        .o_src_ready   (src_ready),
        .i_ready       (ready_slv),
        .o_valid       (valid),
        .o_data_en     (data_en),
        .o_data_in     (data_in),
        .o_busy        (busy),
        .o_timeout_err (timeout_err),
        .i_err_clr     (err_clr),
        .o_tx_count    (tx_count)
    );

    always #5 clk = ~clk;

    // Slave: ready is a registered copy of data_en; hold models a stalled slave.
    always @(posedge clk) ready_slv <= hold ? 1'b0 : data_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_try(input logic [7:0] b);
        src_valid = 1'b1;
        src_data  = b;
        last_acc  = src_ready;
        if (src_ready) begin
            exp_q.push_back(b);
            n_acc++;
        end
        tick();
        src_valid = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < maxc) begin
            tick();
            k++;
        end
        check("drain_bound", (k < maxc), 1);
    endtask

    task automatic wait_valid(input int maxc);
        int k = 0;
        while (!valid && k < maxc) begin
            tick();
            k++;
        end
        check("valid_bound", (k < maxc), 1);
    endtask

    task automatic check_burst(input string name, input int n);
        check({name, "_xfers"}, xfer_cyc.size(), n);
        for (int i = 1; i < xfer_cyc.size(); i++) begin
            check({name, "_consecutive"}, xfer_cyc[i] - xfer_cyc[i-1], 1);
        end
    endtask

    // Monitor: a transfer happens at the next edge whenever valid && ready now.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (valid && ready_slv) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL xfer_unexpected: got byte %0h expected no transfer", data_in);
                end else begin
                    m_b = exp_q.pop_front();
                    check("xfer_data", data_in, m_b);
                end
                xfer_cyc.push_back(cyc);
            end
            if (!valid) begin
                check("idle_data_zero", data_in, 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int sent;

        rst = 1'b0;
        tick();
        tick();
        check("rst_valid", valid, 0);
        check("rst_data_en", data_en, 0);
        check("rst_busy", busy, 0);
        check("rst_data_in", data_in, 0);
        check("rst_src_ready", src_ready, 1);
        check("rst_tx_count", tx_count, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b1;
        tick();

        // Single byte latency
        xfer_cyc.delete();
        push_try(8'hA5);
        check("t1_busy_e0", busy, 0);
        tick();
        check("t1_data_en_e1", data_en, 1);
        check("t1_data_in_e1", data_in, 8'hA5);
        tick();
        check("t1_ready_e2", ready_slv, 1);
        check("t1_count_e2", tx_count, 0);
        tick();
        check("t1_count_e3", tx_count, 1);
        check("t1_busy_e3", busy, 0);
        check("t1_valid_e3", valid, 0);
        tick();
        check("t1_count_e4", tx_count, 1);
        check_burst("t1", 1);

        // Fill the FIFO while the slave stalls, then burst out
        hold = 1'b1;
        xfer_cyc.delete();
        for (int i = 1; i <= 4; i++) push_try(8'(i));
        check("t2_src_ready_full", src_ready, 0);
        push_try(8'h05);
        check("t2_push_rejected", last_acc, 0);
        hold = 1'b0;
        wait_drain(30);
        check_burst("t2", 4);
        check("t2_count", tx_count, 5);
        check("t2_busy", busy, 0);

        // Timeout: 8 REQ cycles then abort, byte retained
        hold = 1'b1;
        push_try(8'h3C);
        wait_valid(5);
        cnt = 0;
        while (valid && cnt < 30) begin
            cnt++;
            tick();
        end
        check("t3_req_cycles", cnt, 8);
        check("t3_err_set", timeout_err, 1);
        check("t3_busy_abort", busy, 1);
        check("t3_count_held", tx_count, 5);
        hold = 1'b0;
        wait_drain(40);
        check("t3_count_retry", tx_count, 6);
        check("t3_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_err_cleared", timeout_err, 0);

        // err_clr held through the abort edge: set wins
        hold = 1'b1;
        err_clr = 1'b1;
        push_try(8'h5A);
        wait_valid(5);
        cnt = 0;
        while (valid && cnt < 30) begin
            cnt++;
            tick();
        end
        err_clr = 1'b0;
        check("t3b_set_wins", timeout_err, 1);
        hold = 1'b0;
        wait_drain(40);
        check("t3b_count", tx_count, 7);

        // Reset in the middle of a request
        hold = 1'b1;
        push_try(8'h11);
        push_try(8'h22);
        tick();
        check("t4_mid_req", valid, 1);
        rst = 1'b0;
        n_acc = 0;
        tick();
        check("t4_valid", valid, 0);
        check("t4_data_en", data_en, 0);
        check("t4_src_ready", src_ready, 1);
        check("t4_count", tx_count, 0);
        check("t4_busy", busy, 0);
        check("t4_err", timeout_err, 0);
        rst = 1'b1;
        hold = 1'b0;
        xfer_cyc.delete();
        repeat (10) tick();
        check("t4_no_xfer", xfer_cyc.size(), 0);
        check("t4_count_after", tx_count, 0);

        // Push every cycle while one entry is in flight
        xfer_cyc.delete();
        push_try(8'h40);
        tick();
        for (int i = 0; i < 8; i++) begin
            push_try(8'(8'h41 + i));
            check("t5_data_en_high", data_en, 1);
        end
        wait_drain(30);
        check_burst("t5", 9);
        check("t5_count", tx_count, 9);

        // Counter wrap with CNT_W=4
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_acc = 0;
        sent = 0;
        cnt = 0;
        while (sent < 17 && cnt < 200) begin
            push_try(8'(8'h80 + sent));
            if (last_acc) sent++;
            cnt++;
        end
        check("t6_sent", sent, 17);
        wait_drain(40);
        check("t6_wrap", tx_count, 1);

        // Randomized traffic with occasional slave stalls
        for (int i = 0; i < 300; i++) begin
            hold = ($urandom % 4) == 0;
            if ($urandom % 2) push_try(8'($urandom));
            else tick();
        end
        hold = 1'b0;
        wait_drain(100);
        check("rand_count", tx_count, 32'(n_acc % 16));
        check("rand_src_ready", src_ready, 1);
        check("rand_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
